// File: rtl/timer_reg_ctrl.sv
// Bus-side register controller for the 64-bit machine timer: atomic mtimecmp
// updates from 32-bit writes, coherent mtime reads, and gated timer interrupt.
module timer_reg_ctrl #(
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic        IE_RST  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  input  logic [63:0] mtime,
  input  logic        int_timer,
  output logic [63:0] mtimecmp,
  output logic        irq_timer
);

  typedef enum logic {B_IDLE, B_ACK}    bus_state_t;
  typedef enum logic {C_IDLE, C_STAGED} cmp_state_t;

  bus_state_t  bus_state;
  cmp_state_t  cmp_state;
  logic [31:0] staging;
  logic [31:0] shadow_hi;
  logic        shadow_vld;
  logic        ie;
  logic [31:0] rd_hold;
  logic [31:0] rd_mux;
  logic [2:0]  reg_idx;
  logic        addr_unused;

  always_comb begin
    reg_idx     = bus_addr[4:2];
    addr_unused = ^bus_addr[1:0];
    rd_mux      = '0;
    case (reg_idx)
      3'd0: rd_mux = mtime[31:0];
      3'd1: rd_mux = shadow_vld ? shadow_hi : mtime[63:32];
      3'd2: rd_mux = mtimecmp[31:0];
      3'd3: rd_mux = mtimecmp[63:32];
      3'd4: rd_mux = {31'b0, ie};
      3'd5: rd_mux = {29'b0, shadow_vld, (cmp_state == C_STAGED), int_timer};
      default: rd_mux = '0;
    endcase
  end

  // Read data and all side effects are taken at the accept edge; the ack
  // cycle only publishes the held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state  <= B_IDLE;
      cmp_state  <= C_IDLE;
      staging    <= '0;
      shadow_hi  <= '0;
      shadow_vld <= 1'b0;
      ie         <= IE_RST;
      rd_hold    <= '0;
      bus_rdata  <= '0;
      bus_ack    <= 1'b0;
      mtimecmp   <= CMP_RST;
      irq_timer  <= 1'b0;
    end else begin
      irq_timer <= int_timer & ie;
      bus_ack   <= 1'b0;
      case (bus_state)
        B_IDLE: begin
          if (bus_req) begin
            bus_state <= B_ACK;
            rd_hold   <= bus_we ? '0 : rd_mux;
            if (!bus_we) begin
              if (reg_idx == 3'd0) begin
                shadow_hi  <= mtime[63:32];
                shadow_vld <= 1'b1;
              end else if (reg_idx == 3'd1) begin
                shadow_vld <= 1'b0;
              end
            end else begin
              case (reg_idx)
                3'd2: begin
                  staging   <= bus_wdata;
                  cmp_state <= C_STAGED;
                end
                3'd3: begin
                  mtimecmp  <= {bus_wdata,
                                (cmp_state == C_STAGED) ? staging : mtimecmp[31:0]};
                  cmp_state <= C_IDLE;
                end
                3'd4: ie <= bus_wdata[0];
                default: ;
              endcase
            end
          end
        end
        B_ACK: begin
          bus_ack   <= 1'b1;
          bus_rdata <= rd_hold;
          bus_state <= B_IDLE;
        end
        default: bus_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_reg_ctrl.sv
// Self-checking bench for timer_reg_ctrl: directed scenarios plus a randomized
// access sequence checked against a register-level reference model.
module tb_timer_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [63:0] mtime = '0;
  logic        int_timer = 1'b0;
  logic [63:0] mtimecmp;
  logic        irq_timer;

  // fnc_timer stand-in controls
  logic [63:0] mt_val = '0;
  logic        mt_load = 1'b0;
  logic        mt_run = 1'b0;
  logic        tmr_mode = 1'b0;
  logic        int_force = 1'b0;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [63:0] m_cmp;
  logic [31:0] m_stg;
  logic        m_st;
  logic [31:0] m_sh;
  logic        m_sv;
  logic        m_ie;
  logic [31:0] rd;
  logic        irq_ack;

  timer_reg_ctrl #(.CMP_RST(64'hFFFF_FFFF_FFFF_FFFF), .IE_RST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .mtime(mtime), .int_timer(int_timer),
    .mtimecmp(mtimecmp), .irq_timer(irq_timer)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mt_load) mtime <= mt_val;
    else if (mt_run) mtime <= mtime + 64'd1;
    int_timer <= tmr_mode ? (mtime >= mtimecmp) : int_force;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_stg = '0; m_st = 1'b0; m_sh = '0; m_sv = 1'b0; m_ie = 1'b0;
  endtask

  task automatic set_mtime(input logic [63:0] v);
    mt_val = v; mt_load = 1'b1;
    tick();
    mt_load = 1'b0;
  endtask

  // Issues one access; returns read data and irq level seen in the ack cycle.
  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d);
    int unsigned n = 0;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    do begin
      tick();
      n++;
    end while (!bus_ack && n < 8);
    check("ack_latency", 64'(n), 64'd2);
    rd = bus_rdata;
    irq_ack = irq_timer;
    bus_req = 1'b0;
    tick();
    check("ack_single_pulse", 64'(bus_ack), 64'd0);
  endtask

  // Full access: model prediction from the register rules, then DUT compare.
  task automatic acc(input logic we, input logic [4:0] a, input logic [31:0] d,
                     input bit chk_irq);
    logic [63:0] mt = mtime;
    logic        iv = int_timer;
    logic [31:0] exp = '0;
    case (a[4:2])
      3'd0: if (!we) begin exp = mt[31:0]; m_sh = mt[63:32]; m_sv = 1'b1; end
      3'd1: if (!we) begin exp = m_sv ? m_sh : mt[63:32]; m_sv = 1'b0; end
      3'd2: if (we) begin m_stg = d; m_st = 1'b1; end else exp = m_cmp[31:0];
      3'd3: if (we) begin m_cmp = {d, m_st ? m_stg : m_cmp[31:0]}; m_st = 1'b0; end
            else exp = m_cmp[63:32];
      3'd4: if (we) m_ie = d[0]; else exp = {31'b0, m_ie};
      3'd5: if (!we) exp = {29'b0, m_sv, m_st, iv};
      default: exp = '0;
    endcase
    bus(we, a, d);
    if (!we) check($sformatf("rdata@%02h", a), 64'(rd), 64'(exp));
    check("mtimecmp", mtimecmp, m_cmp);
    if (chk_irq) check("irq_at_ack", 64'(irq_ack), 64'(int_force & m_ie));
  endtask

  initial begin
    int unsigned found;
    model_reset();

    // reset
    repeat (10) tick();
    check("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_irq", 64'(irq_timer), 64'd0);
    check("rst_ack", 64'(bus_ack), 64'd0);
    check("rst_rdata", 64'(bus_rdata), 64'd0);
    rst_n = 1'b1;
    tick();
    acc(1'b0, 5'h10, '0, 1'b1);
    check("rst_ctrl", 64'(rd), 64'd0);

    // atomic compare update
    tmr_mode = 1'b1;
    acc(1'b1, 5'h10, 32'h1, 1'b0);
    set_mtime(64'h0);
    mt_run = 1'b1;
    acc(1'b1, 5'h08, 32'h20, 1'b0);
    check("cmp_unchanged_after_lo", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    acc(1'b0, 5'h14, '0, 1'b0);
    check("status_staged", 64'(rd[1]), 64'd1);
    acc(1'b1, 5'h0C, 32'h0, 1'b0);
    check("cmp_commit", mtimecmp, 64'h20);
    acc(1'b0, 5'h14, '0, 1'b0);
    check("status_unstaged", 64'(rd[1]), 64'd0);
    found = 0;
    for (int i = 0; i < 64 && found == 0; i++) begin
      if (int_timer) found = 1;
      else tick();
    end
    check("int_timer_rose", 64'(found), 64'd1);
    check("irq_before_delay", 64'(irq_timer), 64'd0);
    tick();
    check("irq_after_delay", 64'(irq_timer), 64'd1);
    mt_run = 1'b0;
    tmr_mode = 1'b0;
    int_force = 1'b0;
    tick();

    // coherent mtime read
    set_mtime(64'h0000_0001_FFFF_FFF0);
    acc(1'b0, 5'h00, '0, 1'b1);
    check("mtime_lo", 64'(rd), 64'hFFFF_FFF0);
    mt_run = 1'b1;
    repeat (32) tick();
    mt_run = 1'b0;
    tick();
    acc(1'b0, 5'h04, '0, 1'b1);
    check("mtime_hi_shadow", 64'(rd), 64'h1);
    acc(1'b0, 5'h04, '0, 1'b1);
    check("mtime_hi_live", 64'(rd), 64'h2);

    // interrupt gating
    acc(1'b1, 5'h10, 32'h0, 1'b1);
    int_force = 1'b1;
    tick(); tick();
    check("irq_gated", 64'(irq_timer), 64'd0);
    acc(1'b1, 5'h10, 32'h1, 1'b1);
    check("irq_enabled", 64'(irq_ack), 64'd1);
    acc(1'b0, 5'h14, '0, 1'b1);
    check("status_raw_int", 64'(rd[0]), 64'd1);
    acc(1'b1, 5'h10, 32'h0, 1'b1);
    check("irq_disabled", 64'(irq_ack), 64'd0);
    acc(1'b0, 5'h14, '0, 1'b1);
    check("status_raw_int_ie0", 64'(rd[0]), 64'd1);

    // unmapped and read-only writes
    acc(1'b0, 5'h18, '0, 1'b1);
    check("unmapped_read", 64'(rd), 64'd0);
    acc(1'b1, 5'h1C, 32'hDEAD, 1'b1);
    acc(1'b1, 5'h00, 32'hDEAD, 1'b1);
    acc(1'b0, 5'h14, '0, 1'b1);
    check("status_after_ro_write", 64'(rd), 64'h1);
    acc(1'b0, 5'h10, '0, 1'b1);

    // randomized accesses against the model
    for (int i = 0; i < 80; i++) begin
      logic [31:0] r0, r1;
      logic [4:0]  a;
      r0 = $urandom; r1 = $urandom;
      int_force = 1'($urandom_range(0, 1));
      set_mtime(($urandom_range(0, 3) == 0) ? {32'h0, 32'hFFFF_FFFF} : {r0, r1});
      a = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      acc(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
    end

    // reset mid-sequence
    int_force = 1'b0;
    acc(1'b1, 5'h08, 32'h55, 1'b1);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 5'h14;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack_dropped", 64'(bus_ack), 64'd0);
    check("mid_rst_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    bus_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check("post_rst_ack", 64'(bus_ack), 64'd0);
    acc(1'b1, 5'h0C, 32'h1, 1'b1);
    check("staging_discarded", mtimecmp, 64'h0000_0001_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
